// File: rtl/alu_result_queue_if.sv
// Handshake bundle between ALU, result queue and writeback.
// Ports: valid/ready, opcode, result, flags {ovf, zero, carry}.
interface alu_result_queue_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;

  modport master (
    output valid, opcode, result, flags,
    input  ready
  );

  modport slave (
    input  valid, opcode, result, flags,
    output ready
  );
endinterface

// File: rtl/alu_result_queue.sv
// ALU result FIFO with sticky flags and saturating op count.
// Ports: clk, rst, alu (slave in), out (master out), sticky_*, op_count, level.
module alu_result_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_result_queue_if.slave        alu,
  alu_result_queue_if.master       out,
  output logic [2:0]               sticky_flags,
  input  logic                     sticky_clear,
  output logic [CNT_W-1:0]         op_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] mem_result [DEPTH];
  logic [3:0]       mem_op     [DEPTH];
  logic [2:0]       mem_flags  [DEPTH];

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       arith;
  logic [2:0] mflags;
  logic [2:0] sticky_base;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign push  = alu.valid & ~full;
  assign pop   = out.ready & ~empty;

  // carry/ovf only carry meaning for ADD and SUB
  assign arith  = (alu.opcode[3:1] == 3'b000);
  assign mflags = {alu.flags[2] & arith,
                   alu.flags[1],
                   alu.flags[0] & arith};

  assign sticky_base = sticky_clear ? 3'b000 : sticky_flags;

  assign alu.ready  = ~full;
  assign out.valid  = ~empty;
  assign out.result = empty ? '0 : mem_result[rd_ptr];
  assign out.opcode = empty ? '0 : mem_op[rd_ptr];
  assign out.flags  = empty ? '0 : mem_flags[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= alu.result;
      mem_op[wr_ptr]     <= alu.opcode;
      mem_flags[wr_ptr]  <= mflags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (push) begin
      sticky_flags <= {sticky_base[2] | mflags[2],
                       mflags[1],
                       sticky_base[0] | mflags[0]};
    end else if (sticky_clear) begin
      sticky_flags <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (push && op_count != '1) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// Randomized plus directed bench for alu_result_queue.
// Checks every cycle against a queue-based reference model.
module tb_alu_result_queue;

  localparam int W = 32;
  localparam int D = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic sticky_clear;
  logic [2:0] sticky_flags;
  logic [CW-1:0] op_count;
  logic [$clog2(D):0] level;

  alu_result_queue_if #(.WIDTH(W)) alu_if ();
  alu_result_queue_if #(.WIDTH(W)) out_if ();

  alu_result_queue #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu          (alu_if.slave),
    .out          (out_if.master),
    .sticky_flags (sticky_flags),
    .sticky_clear (sticky_clear),
    .op_count     (op_count),
    .level        (level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] res;
    logic [2:0]   fl;
  } ent_t;

  ent_t mq[$];
  logic [2:0] m_sticky;
  int m_cnt;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sticky = 3'b000;
    m_cnt = 0;
  endtask

  task automatic check_all();
    check("alu_ready", 64'(alu_if.ready), 64'(mq.size() < D));
    check("out_valid", 64'(out_if.valid), 64'(mq.size() > 0));
    check("level", 64'(level), 64'(mq.size()));
    check("op_count", 64'(op_count), 64'(m_cnt));
    check("sticky", 64'(sticky_flags), 64'(m_sticky));
    if (mq.size() > 0) begin
      check("out_result", 64'(out_if.result), 64'(mq[0].res));
      check("out_opcode", 64'(out_if.opcode), 64'(mq[0].op));
      check("out_flags", 64'(out_if.flags), 64'(mq[0].fl));
    end else begin
      check("empty_data", 64'({out_if.result, out_if.opcode, out_if.flags}), 64'd0);
    end
  endtask

  // check current state, then apply one cycle of stimulus
  task automatic step(input logic v, input logic [3:0] op,
                      input logic [W-1:0] r, input logic c,
                      input logic z, input logic o,
                      input logic ordy, input logic sclr);
    bit do_push;
    bit do_pop;
    logic [2:0] mf;
    logic [2:0] base;
    @(negedge clk);
    check_all();
    alu_if.valid  = v;
    alu_if.opcode = op;
    alu_if.result = r;
    alu_if.flags  = {o, z, c};
    out_if.ready  = ordy;
    sticky_clear  = sclr;
    do_push = v && (mq.size() < D);
    do_pop  = ordy && (mq.size() > 0);
    mf = (op <= 4'd1) ? {o, z, c} : {1'b0, z, 1'b0};
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back('{op: op, res: r, fl: mf});
      base = sclr ? 3'b000 : m_sticky;
      m_sticky = {base[2] | mf[2], mf[1], base[0] | mf[0]};
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (sclr) begin
      m_sticky = 3'b000;
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    sticky_clear = 1'b0;
    alu_if.valid = 1'b0;
    alu_if.opcode = '0;
    alu_if.result = '0;
    alu_if.flags = '0;
    out_if.ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // first push, visible next cycle
    step(1'b1, 4'd0, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    // fill while consumer stalls
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'($urandom_range(0, 7)), $urandom,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // refused push while full with a pop
    step(1'b1, 4'd0, 32'hDEAD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    // masked AND, then SUB overflow
    step(1'b1, 4'd2, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    // clear together with ADD carry/zero, then clear alone
    step(1'b1, 4'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    // steady stream at level 2
    step(1'b1, 4'd3, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd3, 32'h101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 4'd5, 32'h200 + i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // leave 3 entries and reset asynchronously
    step(1'b1, 4'd6, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    alu_if.valid = 1'b0;
    out_if.ready = 1'b0;
    sticky_clear = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // random traffic, long enough to saturate op_count
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 7)), $urandom,
           1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
    @(negedge clk);
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
